// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: sequencer for right-to-left binary modular exponentiation.
// Optional macro CONST_TIME_EN: fixed WIDTH iterations with dummy multiplies on 0 bits.
module mod_exp_ctrl #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] exp_in,
  input  logic             abort,
  output logic             sr_load_shift,
  output logic [WIDTH-1:0] sr_to_load,
  input  logic             sr_bit,
  input  logic             sr_empty,
  output logic             mul_start,
  output logic             mul_sel,
  input  logic             mul_done,
  output logic             init,
  output logic             result_we,
  output logic             base_we,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CHECK = 4'd2,
    S_MUL   = 4'd3,
    S_MUL_W = 4'd4,
    S_SQR   = 4'd5,
    S_SQR_W = 4'd6,
    S_SHIFT = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;
  logic             last_iter_s;

`ifdef CONST_TIME_EN
  // Remembers whether the current multiply is real or a dummy one.
  logic             bit_q, bit_d;
`endif

  assign last_iter_s = (count_q == CW'(WIDTH));

  // State register, shadow exponent and iteration counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shadow_q <= {WIDTH{1'b0}};
      count_q  <= {CW{1'b0}};
`ifdef CONST_TIME_EN
      bit_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
`ifdef CONST_TIME_EN
      bit_q    <= bit_d;
`endif
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    count_d       = count_q;
`ifdef CONST_TIME_EN
    bit_d         = bit_q;
`endif
    sr_load_shift = 1'b0;
    sr_to_load    = shadow_q;
    mul_start     = 1'b0;
    mul_sel       = 1'b0;
    init          = 1'b0;
    result_we     = 1'b0;
    base_we       = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          shadow_d = exp_in;
          count_d  = {CW{1'b0}};
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_LOAD: begin
        init    = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
`ifdef CONST_TIME_EN
        bit_d = sr_bit;
        if (last_iter_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
`else
        if (sr_empty || last_iter_s) begin
          state_d = S_DONE;
        end else if (sr_bit) begin
          state_d = S_MUL;
        end else begin
          state_d = S_SQR;
        end
`endif
      end
      S_MUL: begin
        mul_start = 1'b1;
        mul_sel   = 1'b0;
        state_d   = S_MUL_W;
      end
      S_MUL_W: begin
        mul_sel = 1'b0;
        if (mul_done) begin
`ifdef CONST_TIME_EN
          result_we = bit_q;
`else
          result_we = 1'b1;
`endif
          state_d   = S_SQR;
        end else begin
          state_d   = S_MUL_W;
        end
      end
      S_SQR: begin
        mul_start = 1'b1;
        mul_sel   = 1'b1;
        state_d   = S_SQR_W;
      end
      S_SQR_W: begin
        mul_sel = 1'b1;
        if (mul_done) begin
          base_we = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_SQR_W;
        end
      end
      S_SHIFT: begin
        // The external register shifts this cycle; the shadow tracks it.
        sr_load_shift = 1'b1;
        shadow_d      = shadow_q >> 1;
        count_d       = count_q + CW'(1);
        state_d       = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over every transition and suppresses all completion pulses.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      done      = 1'b0;
      result_we = 1'b0;
      base_we   = 1'b0;
    end else begin
      state_d   = state_d;
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: directed vector table, corner-case sequences
// and randomized exponents checked against an operation/timing model.
module tb_mod_exp_ctrl;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n, start, abort;
  logic [WIDTH-1:0] exp_in, sr_to_load, sr_reg;
  logic             sr_load_shift, sr_bit, sr_empty, mul_start, mul_sel, mul_done;
  logic             init, result_we, base_we, busy, done;
  int               lat_cfg = 1;
  int               mul_cnt;
  bit               inj_en = 1'b0;
  logic             inj_prev;
  int               checks = 0;
  int               errors = 0;

  typedef struct {
    logic [WIDTH-1:0] e;
    int               lat;
    int               rwe, bwe, ms, off;
    logic [63:0]      seq;
  } vec_t;
  vec_t tbl[6];

  mod_exp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(rst_n), .start(start), .exp_in(exp_in), .abort(abort),
    .sr_load_shift(sr_load_shift), .sr_to_load(sr_to_load), .sr_bit(sr_bit),
    .sr_empty(sr_empty), .mul_start(mul_start), .mul_sel(mul_sel), .mul_done(mul_done),
    .init(init), .result_we(result_we), .base_we(base_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Environment: load/shift register and a fixed-latency multiplier.
  assign sr_bit   = sr_reg[0];
  assign sr_empty = (sr_reg == '0);
  assign mul_done = (mul_cnt == 1) || (inj_en && (sr_load_shift || inj_prev));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg   <= '0;
      mul_cnt  <= 0;
      inj_prev <= 1'b0;
    end else begin
      sr_reg   <= sr_load_shift ? (sr_reg >> 1) : sr_to_load;
      mul_cnt  <= mul_start ? lat_cfg : ((mul_cnt != 0) ? mul_cnt - 1 : 0);
      inj_prev <= sr_load_shift | init;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: ops per exponent bit and the cycle at which done must appear.
  function automatic void model(input logic [WIDTH-1:0] e, input int lat,
                                output int rwe, output int bwe, output int ms,
                                output int off, output logic [63:0] seq);
    int iters;
    logic [WIDTH-1:0] v;
    rwe = 0; bwe = 0; ms = 0; off = 3; seq = '0;
`ifdef CONST_TIME_EN
    iters = WIDTH;
    v = e;
`else
    iters = 0;
    v = e;
    while (v != '0) begin iters++; v = v >> 1; end
`endif
    for (int i = 0; i < iters; i++) begin
`ifdef CONST_TIME_EN
      ms++; seq = {seq[62:0], 1'b0}; off += 1 + lat;
      if (e[i]) rwe++;
`else
      if (e[i]) begin ms++; seq = {seq[62:0], 1'b0}; off += 1 + lat; rwe++; end
`endif
      ms++; seq = {seq[62:0], 1'b1}; bwe++; off += 3 + lat;
    end
  endfunction

  task automatic exercise(input string tag, input logic [WIDTH-1:0] e, input int lat,
                          input bit mid_start, input int rwe_e, input int bwe_e,
                          input int ms_e, input int off_e, input logic [63:0] seq_e);
    int n_init, n_done, n_rwe, n_bwe, n_ms, init_t, done_t, t;
    logic [63:0] seq;
    logic busy_after;
    n_init = 0; n_done = 0; n_rwe = 0; n_bwe = 0; n_ms = 0;
    init_t = -1; done_t = -1; t = 0; seq = '0; busy_after = 1'b1;
    @(negedge clk);
    chk({tag, " idle_before"}, {63'd0, busy}, 64'd0);
    start = 1'b1; exp_in = e; lat_cfg = lat;
    while (t < 3000 && !(done_t >= 0 && t >= done_t + 2)) begin
      @(negedge clk);
      t++;
      if (init) begin n_init++; init_t = t; end
      if (done) begin n_done++; if (done_t < 0) done_t = t; end
      if (result_we) n_rwe++;
      if (base_we) n_bwe++;
      if (mul_start) begin n_ms++; seq = {seq[62:0], mul_sel}; end
      if (done_t >= 0 && t == done_t + 1) busy_after = busy;
      if (t == 1) start = 1'b0;
      if (mid_start && t == 8) begin start = 1'b1; exp_in = $urandom; end
      if (mid_start && t == 9) start = 1'b0;
    end
    chk({tag, " init_count"}, n_init, 1);
    chk({tag, " init_time"}, init_t, 1);
    chk({tag, " done_count"}, n_done, 1);
    chk({tag, " done_time"}, done_t, off_e);
    chk({tag, " result_we"}, n_rwe, rwe_e);
    chk({tag, " base_we"}, n_bwe, bwe_e);
    chk({tag, " mul_start"}, n_ms, ms_e);
    chk({tag, " mul_sel_order"}, seq, seq_e);
    chk({tag, " busy_after_done"}, {63'd0, busy_after}, 64'd0);
  endtask

  task automatic run_model(input string tag, input logic [WIDTH-1:0] e, input int lat,
                           input bit mid_start);
    int rwe, bwe, ms, off;
    logic [63:0] seq;
    model(e, lat, rwe, bwe, ms, off, seq);
    exercise(tag, e, lat, mid_start, rwe, bwe, ms, off, seq);
  endtask

  function automatic logic [8:0] outs();
    return {sr_load_shift, mul_start, mul_sel, init, result_we, base_we, busy, done,
            |sr_to_load};
  endfunction

  initial begin
    int n_done, n_rwe;
    bit found;
    logic [WIDTH-1:0] e, mask;
    int lat;

    tbl[0] = '{32'h0000_0000, 3, 0, 0, 0, 3, 64'h0};
    tbl[1] = '{32'h0000_000B, 3, 3, 4, 7, 39, 64'h2D};
    tbl[2] = '{32'h0000_0001, 1, 1, 1, 2, 9, 64'h1};
    tbl[3] = '{32'h0000_0002, 2, 1, 2, 3, 16, 64'h5};
    tbl[4] = '{32'h8000_0000, 1, 1, 32, 33, 133, 64'h1_FFFF_FFFD};
    tbl[5] = '{32'hFFFF_FFFF, 1, 32, 32, 64, 195, 64'h5555_5555_5555_5555};
`ifdef CONST_TIME_EN
    for (int i = 0; i < 6; i++)
      model(tbl[i].e, tbl[i].lat, tbl[i].rwe, tbl[i].bwe, tbl[i].ms, tbl[i].off, tbl[i].seq);
`endif

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; exp_in = '0;
    #3;
    chk("reset_outputs", {55'd0, outs()}, 64'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {55'd0, outs()}, 64'd0);

    for (int i = 0; i < 6; i++)
      exercise($sformatf("vec%0d", i), tbl[i].e, tbl[i].lat, 1'b0, tbl[i].rwe,
               tbl[i].bwe, tbl[i].ms, tbl[i].off, tbl[i].seq);

    // Restart attempt while busy must be ignored.
    run_model("mid_start", 32'h0000_000B, 3, 1'b1);

    // Spurious mul_done in CHECK and SHIFT must not disturb anything.
    inj_en = 1'b1;
    run_model("spurious_done", 32'h0000_000B, 3, 1'b0);
    inj_en = 1'b0;

    // Asynchronous reset while waiting on the square.
    @(negedge clk);
    start = 1'b1; exp_in = 32'h3; lat_cfg = 4;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (mul_start && mul_sel) found = 1'b1;
    end
    chk("reset_reach_sqr", {63'd0, found}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_sqr_w", {55'd0, outs()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_model("after_reset", 32'h0000_000B, 3, 1'b0);

    // Abort in MUL_W on the very cycle mul_done arrives.
    @(negedge clk);
    start = 1'b1; exp_in = 32'h1; lat_cfg = 2;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (mul_start && !mul_sel) found = 1'b1;
    end
    chk("abort_reach_mul", {63'd0, found}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_mul_done_present", {63'd0, mul_done}, 64'd1);
    abort = 1'b1;
    #1;
    chk("abort_no_result_we", {63'd0, result_we}, 64'd0);
    chk("abort_no_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_to_idle", {63'd0, busy}, 64'd0);
    n_done = 0; n_rwe = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (done) n_done++;
      if (result_we) n_rwe++;
    end
    chk("abort_quiet_done", n_done, 0);
    chk("abort_quiet_we", n_rwe, 0);

    // Randomized exponents and multiplier latencies.
    for (int i = 0; i < 24; i++) begin
      mask = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      e    = $urandom & mask;
      lat  = $urandom_range(1, 4);
      run_model($sformatf("rand%0d", i), e, lat, (e > 32'd7) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
